// File: rtl/parity_mem_ctrl_if.sv
// Requester, response and storage-side signals of the parity-protected storage controller.
interface parity_mem_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             REQ_A;
  logic             REQ_B;
  logic             WE_A;
  logic             WE_B;
  logic [7:0]       WDATA_A;
  logic [7:0]       WDATA_B;
  logic             GNT_A;
  logic             GNT_B;
  logic             ACK_A;
  logic             ACK_B;
  logic             ERR_A;
  logic             ERR_B;
  logic [7:0]       RDATA;
  logic             BUSY;
  logic [CNT_W-1:0] ERR_CNT;
  logic             MEM_RD;
  logic             MEM_WR;
  logic [7:0]       MEM_DIN;
  logic [7:0]       MEM_DOUT;
  logic             MEM_PE;

  // Requesters plus storage model side.
  modport master (
    output REQ_A, REQ_B, WE_A, WE_B, WDATA_A, WDATA_B, MEM_DOUT, MEM_PE,
    input  GNT_A, GNT_B, ACK_A, ACK_B, ERR_A, ERR_B, RDATA, BUSY, ERR_CNT,
           MEM_RD, MEM_WR, MEM_DIN
  );

  // Controller side.
  modport slave (
    input  REQ_A, REQ_B, WE_A, WE_B, WDATA_A, WDATA_B, MEM_DOUT, MEM_PE,
    output GNT_A, GNT_B, ACK_A, ACK_B, ERR_A, ERR_B, RDATA, BUSY, ERR_CNT,
           MEM_RD, MEM_WR, MEM_DIN
  );
endinterface

// File: rtl/parity_mem_ctrl.sv
// Round-robin sequencer for the parity-protected 8-bit storage: write-then-verify,
// bounded retries, per-requester completion/failure reporting.
module parity_mem_ctrl #(
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned CNT_W     = 8
) (
  input logic              CLK,
  input logic              RSTN,
  parity_mem_ctrl_if.slave bus
);
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RETRY_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_VERIFY,
    S_READ,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;   // 0 = A, 1 = B
  logic                rr_q, rr_d;         // preferred requester on a tie
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic                fail_q, fail_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   mem_din_q, mem_din_d;
  logic                gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic                ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic                err_a_q, err_a_d, err_b_q, err_b_d;
  logic                busy_q, busy_d;
  logic                mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic                grant;
  logic                sel_we;
  logic                retry_ok;
  logic                cnt_sat;

  // Next-state, operand capture and registered-output decode.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    wdata_d   = wdata_q;
    retry_d   = retry_q;
    fail_d    = fail_q;
    err_cnt_d = err_cnt_q;
    rdata_d   = rdata_q;
    mem_din_d = mem_din_q;
    grant     = 1'b0;
    sel_we    = 1'b0;
    retry_ok  = (retry_q < RETRY_W'(MAX_RETRY));
    cnt_sat   = &err_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.REQ_A || bus.REQ_B) begin
          owner_d = (bus.REQ_A && bus.REQ_B) ? rr_q : bus.REQ_B;
          sel_we  = owner_d ? bus.WE_B : bus.WE_A;
          wdata_d = owner_d ? bus.WDATA_B : bus.WDATA_A;
          retry_d = '0;
          fail_d  = 1'b0;
          grant   = 1'b1;
          state_d = sel_we ? S_WRITE : S_READ;
        end
      end
      S_WRITE: state_d = S_VERIFY;
      S_VERIFY: begin
        if (!bus.MEM_PE && (bus.MEM_DOUT == wdata_q)) begin
          state_d = S_RESP;
        end else begin
          if (!cnt_sat) err_cnt_d = err_cnt_q + CNT_W'(1);
          if (retry_ok) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = S_WRITE;
          end else begin
            fail_d  = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_READ: begin
        rdata_d = bus.MEM_DOUT;
        if (!bus.MEM_PE) begin
          state_d = S_RESP;
        end else begin
          if (!cnt_sat) err_cnt_d = err_cnt_q + CNT_W'(1);
          if (retry_ok) begin
            retry_d = retry_q + RETRY_W'(1);
          end else begin
            fail_d  = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        rr_d    = ~owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_WRITE) mem_din_d = wdata_d;

    gnt_a_d  = grant & ~owner_d;
    gnt_b_d  = grant & owner_d;
    mem_wr_d = (state_d == S_WRITE);
    mem_rd_d = (state_d == S_VERIFY) || (state_d == S_READ);
    busy_d   = (state_d != S_IDLE);
    ack_a_d  = (state_d == S_RESP) & ~owner_d;
    ack_b_d  = (state_d == S_RESP) & owner_d;
    err_a_d  = ack_a_d & fail_d;
    err_b_d  = ack_b_d & fail_d;
  end

  // State, operand and output registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      rr_q      <= 1'b0;
      wdata_q   <= '0;
      retry_q   <= '0;
      fail_q    <= 1'b0;
      err_cnt_q <= '0;
      rdata_q   <= '0;
      mem_din_q <= '0;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      err_a_q   <= 1'b0;
      err_b_q   <= 1'b0;
      busy_q    <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      wdata_q   <= wdata_d;
      retry_q   <= retry_d;
      fail_q    <= fail_d;
      err_cnt_q <= err_cnt_d;
      rdata_q   <= rdata_d;
      mem_din_q <= mem_din_d;
      gnt_a_q   <= gnt_a_d;
      gnt_b_q   <= gnt_b_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      err_a_q   <= err_a_d;
      err_b_q   <= err_b_d;
      busy_q    <= busy_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
    end
  end

  assign bus.GNT_A   = gnt_a_q;
  assign bus.GNT_B   = gnt_b_q;
  assign bus.ACK_A   = ack_a_q;
  assign bus.ACK_B   = ack_b_q;
  assign bus.ERR_A   = err_a_q;
  assign bus.ERR_B   = err_b_q;
  assign bus.RDATA   = rdata_q;
  assign bus.BUSY    = busy_q;
  assign bus.ERR_CNT = err_cnt_q;
  assign bus.MEM_RD  = mem_rd_q;
  assign bus.MEM_WR  = mem_wr_q;
  assign bus.MEM_DIN = mem_din_q;
endmodule

// File: tb/tb_parity_mem_ctrl.sv
// Bench for parity_mem_ctrl: storage stub with fault knobs, transaction-level
// timeline model checked every cycle, plus directed latency/result checks.
module tb_parity_mem_ctrl;
  localparam int unsigned MAX_RETRY = 2;
  localparam int unsigned CNT_W     = 8;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  parity_mem_ctrl_if #(.CNT_W(CNT_W)) bus ();

  parity_mem_ctrl #(.MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  // Storage stub: byte plus stored parity bit, with forced-parity and corrupt-read knobs.
  logic [7:0] st_mem  = 8'h00;
  logic       st_par  = 1'b0;
  int         rd_seen = 0;
  bit         force_pe = 1'b0;
  int         corrupt_until = 0;
  logic [7:0] st_dout;

  always @(posedge CLK) begin
    if (bus.MEM_WR) begin
      st_mem <= bus.MEM_DIN;
      st_par <= ^bus.MEM_DIN;
    end
    if (bus.MEM_RD) rd_seen <= rd_seen + 1;
  end

  assign st_dout      = (rd_seen < corrupt_until) ? 8'h00 : st_mem;
  assign bus.MEM_DOUT = st_dout;
  assign bus.MEM_PE   = force_pe | ((^st_dout) ^ st_par);

  // Per-cycle expectation produced by the transaction model.
  typedef struct packed {
    logic       gnt_a, gnt_b, ack_a, ack_b, err_a, err_b, rd, wr, busy;
    logic       din_set;
    logic [7:0] din;
    logic       cnt_inc;
    logic       rd_load;
    logic [7:0] rdv;
  } cyc_t;

  cyc_t             q[$];
  logic [7:0]       m_mem   = 8'h00;
  logic             m_ptr   = 1'b0;
  logic [7:0]       m_din   = 8'h00;
  logic [7:0]       m_rdata = 8'h00;
  logic [CNT_W-1:0] m_cnt   = '0;

  int n_cmp = 0;
  int n_bad = 0;

  // Expand one accepted request into its expected cycle sequence.
  function automatic void plan(input logic own, input logic we, input logic [7:0] d);
    int         cl;
    logic [7:0] dout;
    logic       pe;
    logic       fail;
    cyc_t       r;
    cl   = corrupt_until - rd_seen;
    fail = 1'b1;
    for (int k = 0; k <= int'(MAX_RETRY); k++) begin
      if (we) begin
        r = '0;
        r.busy = 1'b1; r.wr = 1'b1; r.din_set = 1'b1; r.din = d;
        if (k == 0) begin r.gnt_a = ~own; r.gnt_b = own; end
        q.push_back(r);
        m_mem = d;
      end
      dout = (cl > 0) ? 8'h00 : m_mem;
      cl   = cl - 1;
      pe   = force_pe | ((^dout) != (^m_mem));
      r = '0;
      r.busy = 1'b1; r.rd = 1'b1;
      if (!we && k == 0) begin r.gnt_a = ~own; r.gnt_b = own; end
      if (we) r.cnt_inc = pe || (dout != d);
      else begin r.cnt_inc = pe; r.rd_load = 1'b1; r.rdv = dout; end
      q.push_back(r);
      if (!r.cnt_inc) begin
        fail = 1'b0;
        break;
      end
    end
    r = '0;
    r.busy = 1'b1; r.ack_a = ~own; r.ack_b = own;
    r.err_a = ~own & fail; r.err_b = own & fail;
    q.push_back(r);
    m_ptr = ~own;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  task automatic compare_loop();
    cyc_t r;
    logic idle;
    logic own;
    logic [9+8+8+CNT_W-1:0] e_v, a_v;
    forever begin
      @(negedge CLK);
      idle = 1'b0;
      if (!RSTN) begin
        q.delete();
        m_cnt = '0; m_din = 8'h00; m_rdata = 8'h00; m_ptr = 1'b0;
        r = '0;
      end else if (q.size() > 0) begin
        r = q.pop_front();
      end else begin
        r = '0;
        idle = 1'b1;
      end
      if (r.din_set) m_din = r.din;
      e_v = {r.gnt_a, r.gnt_b, r.ack_a, r.ack_b, r.err_a, r.err_b, r.rd, r.wr, r.busy,
             m_din, m_rdata, m_cnt};
      a_v = {bus.GNT_A, bus.GNT_B, bus.ACK_A, bus.ACK_B, bus.ERR_A, bus.ERR_B,
             bus.MEM_RD, bus.MEM_WR, bus.BUSY, bus.MEM_DIN, bus.RDATA, bus.ERR_CNT};
      n_cmp++;
      if (a_v !== e_v) begin
        n_bad++;
        $display("FAIL cycle_outputs at %0t: got %h, expected %h (gnt,ack,err,rd,wr,busy|din|rdata|cnt)",
                 $time, a_v, e_v);
      end
      if (r.cnt_inc && (m_cnt != '1)) m_cnt = m_cnt + CNT_W'(1);
      if (r.rd_load) m_rdata = r.rdv;
      if (idle && (bus.REQ_A || bus.REQ_B)) begin
        own = (bus.REQ_A && bus.REQ_B) ? m_ptr : bus.REQ_B;
        plan(own, own ? bus.WE_B : bus.WE_A, own ? bus.WDATA_B : bus.WDATA_A);
      end
    end
  endtask

  // Raise requests, drop each on its grant, and wait (bounded) for all acks.
  task automatic go(input logic ra, input logic wa, input logic [7:0] da,
                    input logic rb, input logic wb, input logic [7:0] db,
                    output int lat_a, output int lat_b,
                    output logic ea, output logic eb, output logic [7:0] rdv);
    logic done_a, done_b;
    @(posedge CLK); #1;
    bus.REQ_A = ra; bus.WE_A = wa; bus.WDATA_A = da;
    bus.REQ_B = rb; bus.WE_B = wb; bus.WDATA_B = db;
    lat_a = -1; lat_b = -1; ea = 1'b0; eb = 1'b0; rdv = 8'h00;
    done_a = ~ra; done_b = ~rb;
    for (int c = 0; c < 200 && !(done_a && done_b); c++) begin
      @(negedge CLK);
      if (bus.GNT_A) bus.REQ_A = 1'b0;
      if (bus.GNT_B) bus.REQ_B = 1'b0;
      if (bus.ACK_A) begin lat_a = c; ea = bus.ERR_A; rdv = bus.RDATA; done_a = 1'b1; end
      if (bus.ACK_B) begin lat_b = c; eb = bus.ERR_B; rdv = bus.RDATA; done_b = 1'b1; end
    end
    if (!(done_a && done_b)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_timeout: got no ack within 200 cycles, expected ack A=%0b B=%0b", ra, rb);
      bus.REQ_A = 1'b0;
      bus.REQ_B = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int         la, lb;
    logic       ea, eb;
    logic [7:0] rv;
    logic       seen_rd;

    bus.REQ_A = 1'b0; bus.REQ_B = 1'b0; bus.WE_A = 1'b0; bus.WE_B = 1'b0;
    bus.WDATA_A = 8'h00; bus.WDATA_B = 8'h00;
    fork
      compare_loop();
    join_none

    repeat (2) @(posedge CLK);
    #2;
    chk("reset_busy", int'(bus.BUSY), 0);
    chk("reset_err_cnt", int'(bus.ERR_CNT), 0);
    RSTN = 1'b1;

    // Clean write of 0xA5 by A.
    go(1, 1, 8'hA5, 0, 0, 8'h00, la, lb, ea, eb, rv);
    chk("wr_a5_ack_lat", la, 3);
    chk("wr_a5_err", int'(ea), 0);
    chk("wr_a5_err_cnt", int'(bus.ERR_CNT), 0);

    // Read back by B.
    go(0, 0, 8'h00, 1, 0, 8'h00, la, lb, ea, eb, rv);
    chk("rd_b_ack_lat", lb, 2);
    chk("rd_b_err", int'(eb), 0);
    chk("rd_b_rdata", int'(rv), 'hA5);

    // Simultaneous requests: A write wins, B read follows ACK + idle.
    go(1, 1, 8'h11, 1, 0, 8'h00, la, lb, ea, eb, rv);
    chk("tie_a_lat", la, 3);
    chk("tie_b_lat", lb, 6);
    chk("tie_b_rdata", int'(rv), 'h11);

    // Pointer back at A after B was served.
    go(1, 0, 8'h00, 1, 0, 8'h00, la, lb, ea, eb, rv);
    chk("rr_a_lat", la, 2);
    chk("rr_b_lat", lb, 5);

    // Parity error on every read: retries exhausted.
    force_pe = 1'b1;
    go(1, 0, 8'h00, 0, 0, 8'h00, la, lb, ea, eb, rv);
    force_pe = 1'b0;
    chk("pe_rd_lat", la, 4);
    chk("pe_rd_err", int'(ea), 1);
    chk("pe_rd_err_cnt", int'(bus.ERR_CNT), 3);

    // First verify returns 0x00 for a write of 0x3C: one rewrite, then success.
    corrupt_until = rd_seen + 1;
    go(0, 0, 8'h00, 1, 1, 8'h3C, la, lb, ea, eb, rv);
    chk("cmp_wr_lat", lb, 5);
    chk("cmp_wr_err", int'(eb), 0);
    chk("cmp_wr_err_cnt", int'(bus.ERR_CNT), 4);
    go(1, 0, 8'h00, 0, 0, 8'h00, la, lb, ea, eb, rv);
    chk("cmp_rd_rdata", int'(rv), 'h3C);

    // Write that never verifies: three attempts, failure reported.
    force_pe = 1'b1;
    go(1, 1, 8'h5A, 0, 0, 8'h00, la, lb, ea, eb, rv);
    force_pe = 1'b0;
    chk("pe_wr_lat", la, 7);
    chk("pe_wr_err", int'(ea), 1);
    chk("pe_wr_err_cnt", int'(bus.ERR_CNT), 7);

    // Reset asserted during VERIFY of a B write.
    @(posedge CLK); #1;
    bus.REQ_B = 1'b1; bus.WE_B = 1'b1; bus.WDATA_B = 8'h77;
    seen_rd = 1'b0;
    for (int c = 0; c < 20 && !seen_rd; c++) begin
      @(negedge CLK);
      if (bus.GNT_B) bus.REQ_B = 1'b0;
      if (bus.MEM_RD) seen_rd = 1'b1;
    end
    chk("rst_mid_reached_verify", int'(seen_rd), 1);
    #2;
    RSTN = 1'b0;
    #1;
    chk("rst_async_outputs",
        int'({bus.GNT_A, bus.GNT_B, bus.ACK_A, bus.ACK_B, bus.ERR_A, bus.ERR_B,
              bus.MEM_RD, bus.MEM_WR, bus.BUSY}), 0);
    chk("rst_async_err_cnt", int'(bus.ERR_CNT), 0);
    chk("rst_async_din_rdata", int'({bus.MEM_DIN, bus.RDATA}), 0);
    bus.REQ_B = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    RSTN = 1'b1;
    go(1, 1, 8'h99, 1, 0, 8'h00, la, lb, ea, eb, rv);
    chk("post_rst_a_lat", la, 3);
    chk("post_rst_b_lat", lb, 6);
    chk("post_rst_b_rdata", int'(rv), 'h99);

    // Drive the error counter into saturation: 86 failed reads x 3 attempts.
    force_pe = 1'b1;
    for (int i = 0; i < 86; i++) go(1, 0, 8'h00, 0, 0, 8'h00, la, lb, ea, eb, rv);
    force_pe = 1'b0;
    chk("sat_err_cnt", int'(bus.ERR_CNT), 255);
    chk("sat_last_err", int'(ea), 1);

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/parity_mem_ctrl.md
# parity_mem_ctrl

Sequencing and arbitration controller for the 8-bit parity-protected storage path: parity generator, storage element, parity checker and error flag. Two requesters (A, B) share the storage through round-robin arbitration. The block drives the storage RD/WR strobes and performs write-then-verify on every write. It re-reads or re-writes on a parity or compare failure, up to a bounded retry count, then reports per-requester completion or failure.

## Interface
Parameters:
- MAX_RETRY, default 2: maximum retries after the first attempt; legal range 0-7.
- CNT_W, default 8: width of the saturating parity-error counter.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RSTN  input  1  reset, asynchronous, active-low.
- REQ_A / REQ_B  input  1  access request; held until the matching GNT pulse.
- WE_A / WE_B  input  1  1 = write, 0 = read; valid while REQ is high.
- WDATA_A / WDATA_B  input  8  write data; valid while REQ is high.
- GNT_A / GNT_B  output  1  one-cycle pulse; request accepted and operands latched.
- ACK_A / ACK_B  output  1  one-cycle pulse; operation finished.
- ERR_A / ERR_B  output  1  valid with ACK; 1 = operation failed after retries.
- RDATA  output  8  read result; valid in the ACK cycle of a successful read.
- BUSY  output  1  high in every state except IDLE.
- ERR_CNT  output  CNT_W  count of failed attempts (parity or compare); saturates at all-ones.
- MEM_RD  output  1  storage read strobe (drives storage READ).
- MEM_WR  output  1  storage write strobe (drives storage WRITE).
- MEM_DIN  output  8  storage write data; also feeds the parity generator.
- MEM_DOUT  input  8  storage read data, combinational during MEM_RD.
- MEM_PE  input  1  parity-checker result; 1 = parity error; sampled only during MEM_RD.

## Operation
- States: IDLE, WRITE, VERIFY, READ, RESP. Only one operation is in flight at a time.
- IDLE: if any REQ is high, choose the winner:
  - one requester high: it wins;
  - both high: the round-robin pointer picks (pointer = A after reset).
- On a winner, latch WE, WDATA and the owner. Next state is WRITE if WE = 1, else READ. Clear the retry counter.
- GNT_owner pulses during the first cycle of WRITE/READ. A losing requester keeps REQ high and is re-evaluated at the next IDLE.
- WRITE: MEM_WR = 1 and MEM_DIN = latched data for one cycle; then VERIFY.
- VERIFY: MEM_RD = 1 for one cycle; sample MEM_PE and MEM_DOUT at the closing edge.
  - Pass (MEM_PE = 0 and MEM_DOUT == latched data): go to RESP with ERR = 0.
  - Fail: increment ERR_CNT. If retry < MAX_RETRY, increment retry and return to WRITE; otherwise go to RESP with ERR = 1.
- READ: MEM_RD = 1 for one cycle; sample as in VERIFY.
  - MEM_PE = 0: latch MEM_DOUT into RDATA; go to RESP with ERR = 0.
  - MEM_PE = 1: increment ERR_CNT. If retry < MAX_RETRY, retry++ and stay in READ for another cycle; otherwise go to RESP with ERR = 1.
  - On failure RDATA holds the last sampled MEM_DOUT.
- RESP: ACK_owner = 1, ERR_owner = fail flag, pointer set to the non-owner; then IDLE.
- MEM_RD and MEM_WR are registered, mutually exclusive, and 0 outside their states. MEM_DIN holds its last value when idle.
- ERR_CNT does not wrap; it clears only on reset.

## Timing
- Reset (RSTN = 0, at any time, including mid-operation):
  - state = IDLE, pointer = A, retry = 0;
  - all outputs 0, including ERR_CNT, RDATA and MEM_DIN;
  - the aborted operation gets no ACK; the requester must re-request.
- Cycle n is the IDLE cycle in which REQ is seen.
- Write, clean pass: GNT and MEM_WR at n+1, MEM_RD at n+2, ACK at n+3. Each write retry adds 2 cycles.
- Read, clean pass: GNT and MEM_RD at n+1, ACK at n+2. Each read retry adds 1 cycle.
- Back-to-back: the earliest next grant comes at ACK+2 (ACK cycle, then IDLE sampling cycle).
- MAX_RETRY = 0: the first failure goes directly to RESP with ERR = 1.

## Test plan
- Single write of 0xA5 by A, clean storage: GNT_A at n+1, MEM_WR at n+1, MEM_RD at n+2, ACK_A = 1 and ERR_A = 0 at n+3; ERR_CNT = 0.
- Read after that write by B: ACK_B at n+2 with RDATA = 0xA5, ERR_B = 0.
- REQ_A and REQ_B both high in the same cycle after reset: A granted first; B granted immediately after A's ACK plus one IDLE cycle; then the pointer returns to A.
- Force MEM_PE = 1 on every read, MAX_RETRY = 2, read by A: 3 MEM_RD cycles, ACK_A with ERR_A = 1 at n+4, ERR_CNT = 3.
- Corrupt the first VERIFY only (MEM_DOUT = 0x00 for a write of 0x3C): one rewrite; ACK at n+5 with ERR = 0; ERR_CNT increments by 1.
- Assert RSTN = 0 during VERIFY: all outputs 0 asynchronously, no ACK issued; a new request after release is granted with pointer = A.
